// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: control-word layout and well-known constants.
package mips_pkg;

    localparam int CTRL_W = 9;

    // Bit positions inside the 9-bit control word carried down the pipe
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_BRANCH   = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;
    localparam logic [4:0]        REG_ZERO    = 5'd0;

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use hazard detection against the instruction currently in EX.
module load_use_detect
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_hold,
    output logic             luh,
    output logic             stall
);

    // A load targeting $zero never produces a value worth waiting for
    always_comb begin
        luh   = ex_valid && ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) && id_valid &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));
        stall = luh || ex_hold;
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, EX hold and a
// saturating stall-cycle counter for debug.
module id_ex_pipe_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic luh;

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
        .ex_rt       (ex_rt),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_hold     (ex_hold),
        .luh         (luh),
        .stall       (stall)
    );

    // Hold beats flush so a redirect raised during a multi-cycle op is re-presented later
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_pc4    <= '0;
            ex_ctrl   <= CTRL_BUBBLE;
        end else if (!ex_hold) begin
            if (flush || luh) begin
                ex_valid  <= 1'b0;
                ex_rs     <= '0;
                ex_rt     <= '0;
                ex_rd     <= '0;
                ex_rdata1 <= '0;
                ex_rdata2 <= '0;
                ex_imm    <= '0;
                ex_pc4    <= '0;
                ex_ctrl   <= CTRL_BUBBLE;
            end else begin
                ex_valid  <= id_valid;
                ex_rs     <= id_rs;
                ex_rt     <= id_rt;
                ex_rd     <= id_rd;
                ex_rdata1 <= id_rdata1;
                ex_rdata2 <= id_rdata2;
                ex_imm    <= id_imm;
                ex_pc4    <= id_pc4;
                ex_ctrl   <= id_valid ? id_ctrl : CTRL_BUBBLE;
            end
        end
    end

    // Counts hazard bubbles even when a simultaneous flush is what actually squashes
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (luh && !ex_hold && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection. Sits between decode and execute, and feeds the forwarding unit's ID/EX Rs/Rt inputs and the EX operand muxes. Produces the stall signal that freezes PC and IF/ID. Inserts bubbles on load-use hazards and on flush, and counts stall cycles for debug.

Parameters:
DATA_W, 32, register-file data / immediate / PC width
REG_W, 5, register specifier width
CNT_W, 16, stall-counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  decode stage holds a real instruction
id_rs  in  REG_W  decoded Rs
id_rt  in  REG_W  decoded Rt
id_rd  in  REG_W  decoded Rd
id_rdata1  in  DATA_W  register-file read data 1
id_rdata2  in  DATA_W  register-file read data 2
id_imm  in  DATA_W  sign-extended immediate
id_pc4  in  DATA_W  PC+4
id_ctrl  in  9  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[1:0], Branch}
flush  in  1  branch taken / redirect; squash the instruction entering EX
ex_hold  in  1  EX busy (multi-cycle op); freeze register
stall  out  1  freeze PC and IF/ID this cycle
ex_valid  out  1  EX instruction valid
ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers (to forwarding unit)
ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered operands
ex_ctrl  out  9  registered control bits
stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset: all registered outputs are 0, including ex_valid, ex_ctrl and stall_cnt. stall is 0 because it derives from zeroed state.
- Hazard detection is combinational from registered state:
  - luh = ex_valid & ex_ctrl.MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - stall = luh | ex_hold.
- Per-edge priority, highest first:
  1. reset: clear everything.
  2. ex_hold = 1: all ex_* hold their values (flush is ignored while ex_hold is high; the upstream stage re-presents the branch).
  3. flush = 1: load a bubble (ex_valid = 0, ex_ctrl = 0, data fields don't-care but driven to 0).
  4. luh = 1: load a bubble, as in item 3.
  5. Otherwise: load all id_* fields; ex_valid = id_valid; ex_ctrl = id_ctrl when id_valid is high, else 0.
- Bubble guarantee: the ex_ctrl RegWrite, MemRead and MemWrite bits are never 1 while ex_valid = 0.
- Latency: one cycle from ID to EX outputs. A load-use hazard costs exactly one bubble cycle. After the bubble, ex_ctrl.MemRead = 0, so stall drops and the held instruction loads on the next edge.
- Back-to-back loads: a load followed by a dependent load gives one bubble each time. Two independent loads give no stall.
- $zero rule: a load to register 0 never stalls.
- stall_cnt:
  - Increments by 1 on each edge where luh = 1 and ex_hold = 0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Only reset clears it.
- Simultaneous flush and luh: flush wins; one bubble; the counter still increments (luh is true).
- Reset asserted mid-stall: the next cycle shows a bubble with stall = 0.

Decomposition:
- Shared package mips_pkg:
  - ctrl bit index constants: CTRL_REGWRITE = 8 … CTRL_BRANCH = 0.
  - CTRL_W = 9.
  - CTRL_BUBBLE = 9'b0.
  - REG_ZERO = 5'd0.
- One natural sub-module, load_use_detect: the purely combinational luh/stall logic. The register and counter stay in the top level.

Test Plan:
- Reset then plain load: reset for 2 cycles, then id_valid = 1, rs = 3, rt = 4, rd = 5, rdata1 = 0x11, id_ctrl = RegWrite|RegDst|ALUOp=10 → next edge ex_rs = 3, ex_rdata1 = 0x11, ex_valid = 1, stall = 0.
- Load-use: lw $8,0($9) enters EX (MemRead = 1, ex_rt = 8); ID presents add with rs = 8 → stall = 1 that cycle. Next edge: ex_valid = 0, ex_ctrl = 0, stall_cnt = 1, stall = 0. Following edge: add appears in EX.
- $zero / no-dependency: lw with ex_rt = 0 and ID rs = 0 → stall = 0. lw rt = 8 with ID rs = 9, rt = 10 → stall = 0.
- Flush + hazard simultaneously: load-use condition true and flush = 1 → bubble loaded, stall_cnt increments by 1, no second bubble after.
- ex_hold: hold for 3 cycles while ID inputs change → ex_* unchanged, stall = 1 for all 3 cycles. Release → ID values load on the next edge.
- Counter saturation: CNT_W = 4, force 20 consecutive load-use pairs → stall_cnt stops at 15.
